// File: rtl/game_link_rx.sv
// game_link_rx: decodes 5-byte checksummed frames (A5 CMD DHI DLO CHK) from
// the board-to-board UART into remote ENTER / TURN_DONE pulses and a remote
// HP value. Rejected frames and mid-frame byte gaps raise frame_err, and
// link_alive tracks whether valid frames are still arriving.
//
// Byte handshake: rx_valid is a one-cycle strobe per byte and rx_data is only
// looked at in that cycle. There is no backpressure, so every strobed byte is
// consumed in the cycle it arrives.
module game_link_rx #(
    parameter logic [9:0] HP_INIT      = 10'd100,
    parameter int         BYTE_TIMEOUT = 1_000_000,
    parameter int         LINK_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       enter_pressed_remote,
    output logic       turn_done_remote,
    output logic [9:0] hp_remote,
    output logic       hp_update,
    output logic       frame_err,
    output logic       link_alive,
    output logic [2:0] dbg_state
);

    localparam int BW = $clog2(BYTE_TIMEOUT + 1);
    localparam int LW = $clog2(LINK_TIMEOUT + 1);

    localparam logic [7:0] SYNC       = 8'hA5;
    localparam logic [7:0] CMD_ENTER  = 8'h01;
    localparam logic [7:0] CMD_TURN   = 8'h02;
    localparam logic [7:0] CMD_HP     = 8'h03;

    localparam logic [BW-1:0] GAP_MAX   = BW'(BYTE_TIMEOUT);
    localparam logic [LW-1:0] LINK_MAX  = LW'(LINK_TIMEOUT);
    localparam logic [LW-1:0] LINK_LAST = LW'(LINK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_DHI = 3'd2,
        GET_DLO = 3'd3,
        GET_CHK = 3'd4
    } state_t;

    state_t          state;
    logic [7:0]      cmd_q;
    logic [7:0]      dhi_q;
    logic [7:0]      dlo_q;
    logic [BW-1:0]   gap_cnt;
    logic [LW-1:0]   link_cnt;

    logic            chk_ok;
    logic            is_enter;
    logic            is_turn;
    logic            is_hp;
    logic            frame_good;
    logic            chk_strobe;
    logic            byte_timeout;

    assign dbg_state = state;

    // Frame evaluation uses the latched header plus the CHK byte on the bus.
    always_comb begin
        chk_ok       = ((cmd_q ^ dhi_q ^ dlo_q) == rx_data);
        is_enter     = chk_ok && (cmd_q == CMD_ENTER);
        is_turn      = chk_ok && (cmd_q == CMD_TURN);
        is_hp        = chk_ok && (cmd_q == CMD_HP) && (dhi_q[7:2] == 6'd0);
        frame_good   = is_enter || is_turn || is_hp;
        chk_strobe   = rx_valid && (state == GET_CHK);
        // A byte arriving in the same cycle as the limit wins over the timeout.
        byte_timeout = (state != IDLE) && !rx_valid && (gap_cnt == GAP_MAX);
    end

    // Frame FSM with registered one-cycle result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            cmd_q                <= 8'd0;
            dhi_q                <= 8'd0;
            dlo_q                <= 8'd0;
            hp_remote            <= HP_INIT;
            enter_pressed_remote <= 1'b0;
            turn_done_remote     <= 1'b0;
            hp_update            <= 1'b0;
            frame_err            <= 1'b0;
        end else begin
            enter_pressed_remote <= 1'b0;
            turn_done_remote     <= 1'b0;
            hp_update            <= 1'b0;
            frame_err            <= 1'b0;
            if (byte_timeout) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (rx_valid) begin
                case (state)
                    IDLE: begin
                        // Noise between frames is dropped without an error.
                        if (rx_data == SYNC) state <= GET_CMD;
                    end
                    GET_CMD: begin
                        cmd_q <= rx_data;
                        state <= GET_DHI;
                    end
                    GET_DHI: begin
                        dhi_q <= rx_data;
                        state <= GET_DLO;
                    end
                    GET_DLO: begin
                        dlo_q <= rx_data;
                        state <= GET_CHK;
                    end
                    GET_CHK: begin
                        state                <= IDLE;
                        enter_pressed_remote <= is_enter;
                        turn_done_remote     <= is_turn;
                        frame_err            <= !frame_good;
                        if (is_hp) begin
                            hp_remote <= {dhi_q[1:0], dlo_q};
                            hp_update <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Inter-byte gap counter, only running while a frame is in progress.
    always_ff @(posedge clk) begin
        if (rst || rx_valid || (state == IDLE)) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Link activity timer: reloaded by each valid frame, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_cnt   <= '0;
            link_alive <= 1'b0;
        end else if (chk_strobe && frame_good) begin
            link_cnt   <= '0;
            link_alive <= 1'b1;
        end else begin
            if (link_cnt != LINK_MAX) link_cnt <= link_cnt + 1'b1;
            if (link_cnt == LINK_LAST) link_alive <= 1'b0;
        end
    end

endmodule
